ppm8_modulator: RTL and testbench



---
 rtl/ppm_pkg.sv | 16 +
 rtl/ppm8_modulator_if.sv | 13 +
 rtl/ppm_slot_timer.sv | 53 +++++
 rtl/ppm8_modulator.sv | 102 ++++++++++
 tb/tb_ppm8_modulator.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/ppm_pkg.sv
// Shared 8-ary PPM constants and transmit state encoding.
// Used by the modulator and its slot timer; the receive-side correlator shares the same view.
package ppm_pkg;

  localparam int PPM_ORDER    = 8;
  localparam int PPM_SYM_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GUARD = 2'd2
  } ppm_tx_state_t;

  typedef logic [PPM_SYM_BITS-1:0] ppm_sym_t;

endpackage

// File: rtl/ppm8_modulator_if.sv
// Symbol handshake between the framing/encoder logic (master) and the PPM modulator (slave).
// A symbol transfers on a rising edge with symbol_valid and symbol_ready both high.
interface ppm8_modulator_if;
  import ppm_pkg::*;

  ppm_sym_t symbol_in;
  logic     symbol_valid;
  logic     symbol_ready;

  modport master (output symbol_in, output symbol_valid, input symbol_ready);
  modport slave  (input symbol_in, input symbol_valid, output symbol_ready);

endinterface

// File: rtl/ppm_slot_timer.sv
// Cycle-within-slot and slot-within-frame counter pair, with a clear and a run enable.
// Next-count values are exported so the owner can register outputs one cycle ahead.
module ppm_slot_timer #(
  parameter int SLOT_CYCLES = 4,
  parameter int CYC_W       = 2,
  parameter int SLOT_W      = 3
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              clr,
  input  logic              run,
  input  logic [SLOT_W-1:0] last_slot,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [SLOT_W-1:0] slot_nxt,
  output logic [CYC_W-1:0]  cyc_nxt,
  output logic              last_end
);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);

  logic [CYC_W-1:0] cyc_cnt;
  logic             slot_end;

  assign slot_end = (cyc_cnt == CYC_LAST);
  assign last_end = slot_end && (slot_cnt == last_slot);

  always_comb begin
    cyc_nxt  = cyc_cnt;
    slot_nxt = slot_cnt;
    if (clr) begin
      cyc_nxt  = '0;
      slot_nxt = '0;
    end else if (run) begin
      if (slot_end) begin
        cyc_nxt  = '0;
        slot_nxt = (slot_cnt == last_slot) ? '0 : slot_cnt + 1'b1;
      end else begin
        cyc_nxt = cyc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cyc_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      cyc_cnt  <= cyc_nxt;
      slot_cnt <= slot_nxt;
    end
  end

endmodule

// File: rtl/ppm8_modulator.sv
// 8-ary PPM transmit modulator: one pulse per frame in the symbol's slot, then guard slots.
// One-entry hold register lets the next frame start with zero gap; ready is !hold_full.
module ppm8_modulator
  import ppm_pkg::*;
#(
  parameter int SLOT_CYCLES  = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int GUARD_SLOTS  = 1
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    enable,
  ppm8_modulator_if.slave         sym,
  output logic                    pulse_out,
  output logic                    frame_start,
  output logic                    busy,
  output logic [PPM_SYM_BITS-1:0] slot_idx
);

  localparam int CYC_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int GRD_W  = (GUARD_SLOTS > 1) ? $clog2(GUARD_SLOTS) : 1;
  localparam int SLOT_W = (GRD_W > PPM_SYM_BITS) ? GRD_W : PPM_SYM_BITS;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FRAME = ST_FRAME;
  localparam logic [1:0] S_GUARD = ST_GUARD;

  localparam logic [SLOT_W-1:0] FRAME_LAST = SLOT_W'(PPM_ORDER - 1);
  localparam logic [SLOT_W-1:0] GUARD_LAST = SLOT_W'((GUARD_SLOTS > 0) ? GUARD_SLOTS - 1 : 0);
  localparam logic [CYC_W:0]    PULSE_LEN  = (CYC_W + 1)'(PULSE_CYCLES);

  logic [1:0]        state, state_nxt;
  ppm_sym_t          active_sym, active_nxt, hold_sym, start_sym;
  logic              hold_full, accept, frame_end, start_frame, last_end;
  logic [SLOT_W-1:0] slot_cnt, slot_nxt, last_slot;
  logic [CYC_W-1:0]  cyc_nxt;

  assign sym.symbol_ready = !hold_full;
  assign accept           = sym.symbol_valid && !hold_full;

  // With no guard slots the frame's own last slot is the end-of-frame decision point.
  assign frame_end   = last_end && ((state == S_GUARD) || (state == S_FRAME && GUARD_SLOTS == 0));
  assign start_frame = enable && (hold_full || accept) && ((state == S_IDLE) || frame_end);
  assign start_sym   = hold_full ? hold_sym : sym.symbol_in;
  assign active_nxt  = start_frame ? start_sym : active_sym;
  assign last_slot   = (state == S_GUARD) ? GUARD_LAST : FRAME_LAST;

  ppm_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .CYC_W       (CYC_W),
    .SLOT_W      (SLOT_W)
  ) u_timer (
    .clk       (clk),
    .rstb      (rstb),
    .clr       (start_frame),
    .run       (state != S_IDLE),
    .last_slot (last_slot),
    .slot_cnt  (slot_cnt),
    .slot_nxt  (slot_nxt),
    .cyc_nxt   (cyc_nxt),
    .last_end  (last_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_frame) state_nxt = S_FRAME;
      S_FRAME: if (frame_end) state_nxt = start_frame ? S_FRAME : S_IDLE;
               else if (last_end) state_nxt = S_GUARD;
      S_GUARD: if (frame_end) state_nxt = start_frame ? S_FRAME : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= S_IDLE;
      active_sym  <= '0;
      hold_sym    <= '0;
      hold_full   <= 1'b0;
      pulse_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      active_sym  <= active_nxt;
      frame_start <= start_frame;
      // Registered from next-cycle counts so the pulse lines up with its slot.
      pulse_out   <= (state_nxt == S_FRAME) && (slot_nxt == SLOT_W'(active_nxt)) &&
                     ({1'b0, cyc_nxt} < PULSE_LEN);
      if (start_frame && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept && !start_frame) begin
        hold_sym  <= sym.symbol_in;
        hold_full <= 1'b1;
      end
    end
  end

  assign busy     = (state != S_IDLE);
  assign slot_idx = (state == S_FRAME) ? slot_cnt[PPM_SYM_BITS-1:0] : '0;

endmodule

// File: tb/tb_ppm8_modulator.sv
// Directed bench for ppm8_modulator: default timing instance plus a long-pulse, no-guard instance.
// Cycle 0 is the accept edge; outputs are sampled on the falling edge of each cycle.
module tb_ppm8_modulator;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en_a = 1'b1;
  logic en_b = 1'b1;

  ppm8_modulator_if if_a ();
  ppm8_modulator_if if_b ();

  logic       pulse_a, fs_a, busy_a;
  logic       pulse_b, fs_b, busy_b;
  logic [2:0] slot_a, slot_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ppm8_modulator dut_a (
    .clk         (clk),
    .rstb        (rstb),
    .enable      (en_a),
    .sym         (if_a),
    .pulse_out   (pulse_a),
    .frame_start (fs_a),
    .busy        (busy_a),
    .slot_idx    (slot_a)
  );

  ppm8_modulator #(
    .SLOT_CYCLES  (4),
    .PULSE_CYCLES (4),
    .GUARD_SLOTS  (0)
  ) dut_b (
    .clk         (clk),
    .rstb        (rstb),
    .enable      (en_b),
    .sym         (if_b),
    .pulse_out   (pulse_b),
    .frame_start (fs_b),
    .busy        (busy_b),
    .slot_idx    (slot_b)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  logic [2:0] t3_syms [3];
  int         idx;
  logic       take;

  initial begin
    t3_syms[0] = 3'd2;
    t3_syms[1] = 3'd4;
    t3_syms[2] = 3'd6;
    if_a.symbol_in    = '0;
    if_a.symbol_valid = 1'b0;
    if_b.symbol_in    = '0;
    if_b.symbol_valid = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_pulse", 0, pulse_a, 0);
    chk("rst_fs", 0, fs_a, 0);
    chk("rst_busy", 0, busy_a, 0);
    chk("rst_slot", 0, slot_a, 0);
    chk("rst_ready", 0, if_a.symbol_ready, 1);
    chk("rst_b_pulse", 0, pulse_b, 0);
    chk("rst_b_ready", 0, if_b.symbol_ready, 1);
    rstb = 1'b1;
    @(negedge clk);

    // Single symbol 5 from IDLE
    if_a.symbol_in    = 3'd5;
    if_a.symbol_valid = 1'b1;
    chk("t1_ready0", 0, if_a.symbol_ready, 1);
    @(negedge clk);
    for (int c = 1; c <= 37; c++) begin
      if_a.symbol_valid = 1'b0;
      chk("t1_pulse", c, pulse_a, c == 21);
      chk("t1_fs", c, fs_a, c == 1);
      chk("t1_busy", c, busy_a, c <= 36);
      if (c == 21) chk("t1_slot", c, slot_a, 5);
      if (c == 33) chk("t1_slot_guard", c, slot_a, 0);
      @(negedge clk);
    end

    // Back-to-back symbols 0 then 7
    if_a.symbol_in    = 3'd0;
    if_a.symbol_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 73; c++) begin
      chk("t2_pulse", c, pulse_a, (c == 1) || (c == 65));
      chk("t2_fs", c, fs_a, (c == 1) || (c == 37));
      chk("t2_busy", c, busy_a, c <= 72);
      chk("t2_ready", c, if_a.symbol_ready, !((c >= 2) && (c <= 36)));
      if_a.symbol_valid = (c == 1);
      if_a.symbol_in    = 3'd7;
      @(negedge clk);
    end

    // Three symbols with valid held; third stalls until frame 2 starts
    idx               = 0;
    if_a.symbol_in    = t3_syms[0];
    if_a.symbol_valid = 1'b1;
    take              = if_a.symbol_ready;
    @(negedge clk);
    for (int c = 1; c <= 110; c++) begin
      if (take) idx++;
      if_a.symbol_valid = (idx < 3);
      if (idx < 3) if_a.symbol_in = t3_syms[idx];
      chk("t3_pulse", c, pulse_a, (c == 9) || (c == 53) || (c == 97));
      chk("t3_fs", c, fs_a, (c == 1) || (c == 37) || (c == 73));
      chk("t3_busy", c, busy_a, c <= 108);
      chk("t3_ready", c, if_a.symbol_ready, (c == 1) || (c == 37) || (c >= 73));
      take = if_a.symbol_valid && if_a.symbol_ready;
      @(negedge clk);
    end
    chk("t3_all_taken", 0, idx, 3);

    // Enable dropped mid-frame with a symbol held
    if_a.symbol_in    = 3'd3;
    if_a.symbol_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 50; c++) begin
      chk("t4_pulse", c, pulse_a, (c == 13) || (c == 45));
      chk("t4_fs", c, fs_a, (c == 1) || (c == 41));
      chk("t4_busy", c, busy_a, (c <= 36) || (c >= 41));
      chk("t4_ready", c, if_a.symbol_ready, (c == 1) || (c >= 41));
      if (c == 45) chk("t4_slot", c, slot_a, 1);
      if_a.symbol_valid = (c == 1);
      if_a.symbol_in    = 3'd1;
      en_a              = !((c >= 10) && (c < 40));
      @(negedge clk);
    end
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Reset during the pulse of symbol 5, with symbol 2 held
    if_a.symbol_in    = 3'd5;
    if_a.symbol_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 21; c++) begin
      chk("t5_pulse", c, pulse_a, c == 21);
      chk("t5_busy", c, busy_a, 1);
      if_a.symbol_valid = (c == 1);
      if_a.symbol_in    = 3'd2;
      @(negedge clk);
    end
    rstb = 1'b0;
    #1;
    chk("t5_rst_pulse", 21, pulse_a, 0);
    chk("t5_rst_fs", 21, fs_a, 0);
    chk("t5_rst_busy", 21, busy_a, 0);
    chk("t5_rst_slot", 21, slot_a, 0);
    chk("t5_rst_ready", 21, if_a.symbol_ready, 1);
    @(negedge clk);
    rstb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t5_post_busy", c, busy_a, 0);
      chk("t5_post_pulse", c, pulse_a, 0);
      chk("t5_post_ready", c, if_a.symbol_ready, 1);
    end

    // Long pulse, no guard: 7 then 0 gives one 8-cycle pulse across the boundary
    if_b.symbol_in    = 3'd7;
    if_b.symbol_valid = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 66; c++) begin
      chk("t6_pulse", c, pulse_b, (c >= 29) && (c <= 36));
      chk("t6_fs", c, fs_b, (c == 1) || (c == 33));
      chk("t6_busy", c, busy_b, c <= 64);
      if_b.symbol_valid = (c == 1);
      if_b.symbol_in    = 3'd0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
